// File: rtl/mac_pkg.sv
// Shared widths and FSM state type for the MAC result serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

    localparam int MAC_DATA_W = 16;
    localparam int MAC_OUT_W  = 8;
    localparam int MAC_BEATS  = MAC_DATA_W / MAC_OUT_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO whose head is visible on rdata without read latency.
// Latency: 1 cycle from push to count/rdata update.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/mac_result_serializer.sv
// Buffers MAC results in a FIFO and streams each word as OUT_W beats, low beat first.
// Latency: 2 cycles from in_valid to first beat with an empty FIFO; one beat per cycle after that.
// Backpressure: out_ready stalls the beat stream; the MAC side cannot stall, so a full FIFO drops and sets overflow.
module mac_result_serializer
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int OUT_W  = MAC_OUT_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int NBEATS = DATA_W / OUT_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

    ser_state_t         state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               ovf_q;
    logic               pop;
    logic               push;
    logic [DATA_W-1:0]  head;
    logic [LVL_W-1:0]   level_w;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .count (level_w)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (level_w != '0) begin
                        pop     = 1'b1;
                        shreg_d = head;
                        beat_d  = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (beat_q != LAST_BEAT) begin
                            shreg_d = shreg_q >> OUT_W;
                            beat_d  = beat_q + 1'b1;
                        end else if (level_w != '0) begin
                            // Reload on the last beat so words leave back-to-back.
                            pop     = 1'b1;
                            shreg_d = head;
                            beat_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A full FIFO still accepts when the same edge pops its head.
    assign push = ena & in_valid & ((level_w != FULL_LVL) | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            if (ena & in_valid & ~push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (beat_q == LAST_BEAT);
    assign out_data  = shreg_q[OUT_W-1:0];
    assign level     = level_w;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed scenarios plus random traffic, checked every cycle against a word-queue model of the serializer.
module tb_mac_result_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;

    always #5 clk = ~clk;

    mac_result_serializer #(
        .DATA_W (16),
        .OUT_W  (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    // Model: queued words, the word being sent, which byte of it is showing, sticky drop flag.
    int q[$];
    int cur   = 0;
    int mbeat = 0;
    bit busy  = 1'b0;
    bit movf  = 1'b0;

    int got[$];
    int gotc[$];
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit iv, input logic [15:0] id, input bit rdy, input bit en, input bit rn);
        bit mpop;
        bit mpush;
        if (!rn) begin
            q.delete();
            cur   = 0;
            mbeat = 0;
            busy  = 1'b0;
            movf  = 1'b0;
        end else if (en) begin
            mpop  = (q.size() > 0) && (!busy || (rdy && mbeat == 1));
            mpush = iv && (q.size() < 4 || mpop);
            if (iv && !mpush) movf = 1'b1;
            if (busy && rdy) begin
                if (mbeat == 0) mbeat = 1;
                else if (!mpop) busy = 1'b0;
            end
            if (mpop) begin
                cur   = q.pop_front();
                mbeat = 0;
                busy  = 1'b1;
            end
            if (mpush) q.push_back(int'(id));
        end
    endtask

    task automatic cyc(input bit iv, input logic [15:0] id, input bit rdy, input bit en, input bit rn);
        in_valid  = iv;
        in_data   = id;
        out_ready = rdy;
        ena       = en;
        rst_n     = rn;
        #1;
        if (rn && en && out_valid && rdy) begin
            got.push_back(int'(out_data));
            gotc.push_back(cyc_n);
        end
        @(posedge clk);
        cyc_n++;
        model_step(iv, id, rdy, en, rn);
        #1;
        chk("out_valid", 32'(out_valid), 32'(busy));
        chk("out_last",  32'(out_last),  32'(busy && mbeat == 1));
        chk("out_data",  32'(out_data),  32'((cur >> (8 * mbeat)) & 8'hFF));
        chk("level",     32'(level),     32'(q.size()));
        chk("overflow",  32'(overflow),  32'(movf));
    endtask

    task automatic check_got(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({tag, "_beat"}, 32'(got[i]), 32'(exp_q[i]));
        end
        got.delete();
        gotc.delete();
        exp_q.delete();
    endtask

    int lvl_hold;
    int gap;
    logic [15:0] w;

    initial begin
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        cyc(0, 16'h0, 0, 1, 0);
        cyc(0, 16'h0, 0, 1, 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_last",  32'(out_last),  0);
        chk("rst_level",     32'(level),     0);
        chk("rst_overflow",  32'(overflow),  0);

        // Single word, latency 2
        got.delete(); gotc.delete();
        cyc(1, 16'hBEEF, 1, 1, 1);
        chk("single_level1",   32'(level),     1);
        chk("single_novalid",  32'(out_valid), 0);
        cyc(0, 16'h0, 1, 1, 1);
        chk("single_latency",  32'(out_valid), 1);
        chk("single_lowbyte",  32'(out_data),  32'h00EF);
        for (int i = 0; i < 4; i++) cyc(0, 16'h0, 1, 1, 1);
        exp_q = '{32'hEF, 32'hBE};
        check_got("single");
        chk("single_level0", 32'(level), 0);

        // Back-to-back four words
        cyc(1, 16'h1122, 1, 1, 1);
        cyc(1, 16'h3344, 1, 1, 1);
        cyc(1, 16'h5566, 1, 1, 1);
        cyc(1, 16'h7788, 1, 1, 1);
        for (int i = 0; i < 10; i++) cyc(0, 16'h0, 1, 1, 1);
        gap = (gotc.size() > 0) ? (gotc[gotc.size() - 1] - gotc[0]) : -1;
        chk("b2b_span", 32'(gap), 7);
        exp_q = '{32'h22, 32'h11, 32'h44, 32'h33, 32'h66, 32'h55, 32'h88, 32'h77};
        check_got("b2b");
        chk("b2b_overflow", 32'(overflow), 0);

        // Overflow: six words against a stalled consumer
        for (int k = 0; k < 6; k++) begin
            w = 16'hA001 + 16'(k * 16'h0102);
            cyc(1, w, 0, 1, 1);
            if (k < 5) begin
                exp_q.push_back(int'(w[7:0]));
                exp_q.push_back(int'(w[15:8]));
            end
        end
        chk("ovf_level", 32'(level),    4);
        chk("ovf_flag",  32'(overflow), 1);
        for (int i = 0; i < 12; i++) cyc(0, 16'h0, 1, 1, 1);
        check_got("ovf");
        chk("ovf_sticky", 32'(overflow), 1);

        // Backpressure pattern 1,0,0,1
        cyc(1, 16'hA5C3, 0, 1, 1);
        cyc(0, 16'h0, 0, 1, 1);
        cyc(0, 16'h0, 1, 1, 1);
        cyc(0, 16'h0, 0, 1, 1);
        chk("bp_hold1", 32'(out_data), 32'hA5);
        cyc(0, 16'h0, 0, 1, 1);
        chk("bp_hold2", 32'(out_data), 32'hA5);
        chk("bp_last",  32'(out_last), 1);
        cyc(0, 16'h0, 1, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 1, 1, 1);
        exp_q = '{32'hC3, 32'hA5};
        check_got("bp");

        // Full FIFO, push while the last beat drains
        cyc(0, 16'h0, 0, 1, 0);
        got.delete(); gotc.delete();
        cyc(1, 16'h0102, 0, 1, 1);
        cyc(1, 16'h0304, 0, 1, 1);
        cyc(1, 16'h0506, 0, 1, 1);
        cyc(1, 16'h0708, 0, 1, 1);
        cyc(1, 16'h090A, 0, 1, 1);
        chk("full_level", 32'(level), 4);
        cyc(0, 16'h0, 1, 1, 1);
        cyc(1, 16'h9999, 1, 1, 1);
        chk("full_level_same", 32'(level),    4);
        chk("full_no_ovf",     32'(overflow), 0);
        for (int i = 0; i < 12; i++) cyc(0, 16'h0, 1, 1, 1);
        exp_q = '{32'h02, 32'h01, 32'h04, 32'h03, 32'h06, 32'h05,
                  32'h08, 32'h07, 32'h0A, 32'h09, 32'h99, 32'h99};
        check_got("full");

        // Reset mid-transfer
        cyc(1, 16'h1234, 0, 1, 1);
        cyc(0, 16'h0, 0, 1, 1);
        cyc(0, 16'h0, 1, 1, 1);
        cyc(0, 16'h0, 1, 1, 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_level", 32'(level),     0);
        chk("midrst_ovf",   32'(overflow),  0);
        got.delete(); gotc.delete();
        cyc(1, 16'hABCD, 1, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 16'h0, 1, 1, 1);
        exp_q = '{32'hCD, 32'hAB};
        check_got("midrst");

        // Enable low freezes everything
        cyc(1, 16'h5A6B, 0, 1, 1);
        cyc(0, 16'h0, 0, 1, 1);
        lvl_hold = int'(level);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'hFFFF, 1, 0, 1);
            chk("ena_hold_data",  32'(out_data),  32'h6B);
            chk("ena_hold_valid", 32'(out_valid), 1);
            chk("ena_hold_level", 32'(level),     32'(lvl_hold));
        end
        for (int i = 0; i < 4; i++) cyc(0, 16'h0, 1, 1, 1);
        exp_q = '{32'h6B, 32'h5A};
        check_got("ena");

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 50, 16'($urandom), $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 90, $urandom_range(0, 199) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
